// File: rtl/imadu_pkg.sv
// Shared arithmetic definitions for the iterative divider/multiplier pair:
// operand width default, counter-width helper and the FSM state type.
package imadu_pkg;

    localparam int DEF_WIDTH = 32'sd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Smallest r with 2**r >= value; callers pass count+1 to size a counter reaching count.
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/imadu.sv
// Iterative unsigned multiply-add: prod = a*b + c via radix-2 shift-add,
// one multiplier bit per clock, single-cycle go / level busy handshake.
module imadu
    import imadu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 go,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int PW = 2 * WIDTH;
    localparam int NW = clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [PW-1:0]      p_q, p_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [NW-1:0]      n_q, n_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic               done_q, done_d;
    logic               last_s;
    logic [WIDTH:0]     sum_s;

    assign last_s = (n_q == NW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Upper half plus the multiplicand when the current multiplier bit is set;
    // the extra bit is the carry that re-enters at the MSB on the shift.
    always_comb begin
        if (p_q[0]) begin
            sum_s = {1'b0, p_q[PW-1:WIDTH]} + {1'b0, a_q};
        end else begin
            sum_s = {1'b0, p_q[PW-1:WIDTH]};
        end
    end

    // Datapath next-state: capture on go, shift-add while running, publish on the last step.
    always_comb begin
        p_d    = p_q;
        a_d    = a_q;
        n_d    = n_q;
        prod_d = prod_q;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    p_d = {c, b};
                    a_d = a;
                    n_d = {NW{1'b0}};
                end else begin
                    p_d = p_q;
                end
            end
            ST_RUN: begin
                p_d = {sum_s, p_q[WIDTH-1:1]};
                n_d = n_q + NW'(1);
                if (last_s) begin
                    prod_d = {sum_s, p_q[WIDTH-1:1]};
                    done_d = 1'b1;
                end else begin
                    prod_d = prod_q;
                end
            end
            default: begin
                p_d = p_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            p_q    <= {PW{1'b0}};
            a_q    <= {WIDTH{1'b0}};
            n_q    <= {NW{1'b0}};
            prod_q <= {PW{1'b0}};
            done_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            a_q    <= a_d;
            n_q    <= n_d;
            prod_q <= prod_d;
            done_q <= done_d;
        end
    end

    // Outputs, all taken straight from registers.
    always_comb begin
        busy = (state_q == ST_RUN);
        done = done_q;
        prod = prod_q;
    end

endmodule

// File: tb/tb_imadu.sv
// Bench for imadu: two widths (8, 16) against an arithmetic reference model,
// per-cycle output comparison plus directed literal checks.
module tb_imadu;

    logic        clk = 1'b0;
    logic        arst;
    logic        go8, go16;
    logic [7:0]  a8, b8, c8;
    logic [15:0] a16, b16, c16;
    logic        busy8, done8, busy16, done16;
    logic [15:0] prod8;
    logic [31:0] prod16;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: an operation occupies 8 (or 16) cycles, then result a*b+c appears.
    bit     m8_busy = 1'b0, m8_done = 1'b0, m16_busy = 1'b0, m16_done = 1'b0;
    int     m8_left = 0, m16_left = 0;
    longint m8_res = 0, m8_prod = 0, m16_res = 0, m16_prod = 0;

    always #5 clk = ~clk;

    imadu #(.WIDTH(8)) dut8 (
        .clk(clk), .arst(arst), .go(go8), .a(a8), .b(b8), .c(c8),
        .busy(busy8), .done(done8), .prod(prod8)
    );

    imadu #(.WIDTH(16)) dut16 (
        .clk(clk), .arst(arst), .go(go16), .a(a16), .b(b16), .c(c16),
        .busy(busy16), .done(done16), .prod(prod16)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for the 8-bit instance.
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m8_busy <= 1'b0; m8_done <= 1'b0; m8_prod <= 0; m8_left <= 0;
        end else begin
            m8_done <= 1'b0;
            if (m8_busy) begin
                m8_left <= m8_left - 1;
                if (m8_left == 1) begin
                    m8_busy <= 1'b0; m8_done <= 1'b1; m8_prod <= m8_res;
                end
            end else if (go8) begin
                m8_busy <= 1'b1; m8_left <= 8;
                m8_res  <= longint'(a8) * longint'(b8) + longint'(c8);
            end
        end
    end

    // Reference model for the 16-bit instance.
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m16_busy <= 1'b0; m16_done <= 1'b0; m16_prod <= 0; m16_left <= 0;
        end else begin
            m16_done <= 1'b0;
            if (m16_busy) begin
                m16_left <= m16_left - 1;
                if (m16_left == 1) begin
                    m16_busy <= 1'b0; m16_done <= 1'b1; m16_prod <= m16_res;
                end
            end else if (go16) begin
                m16_busy <= 1'b1; m16_left <= 16;
                m16_res  <= longint'(a16) * longint'(b16) + longint'(c16);
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        check("busy8",  longint'(busy8),  longint'(m8_busy));
        check("done8",  longint'(done8),  longint'(m8_done));
        check("prod8",  longint'(prod8),  m8_prod);
        check("busy16", longint'(busy16), longint'(m16_busy));
        check("done16", longint'(done16), longint'(m16_done));
        check("prod16", longint'(prod16), m16_prod);
    end

    task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv);
        @(posedge clk); #2;
        a8 = av; b8 = bv; c8 = cv; go8 = 1'b1;
        @(posedge clk); #2;
        go8 = 1'b0;
    endtask

    task automatic start16(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] cv);
        @(posedge clk); #2;
        a16 = av; b16 = bv; c16 = cv; go16 = 1'b1;
        @(posedge clk); #2;
        go16 = 1'b0;
    endtask

    // Returns the number of negedges after the go edge until done is seen (-1 on timeout).
    task automatic wait_done8(output int lat);
        lat = -1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_done16(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done16) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic directed8(input string name, input logic [7:0] av, input logic [7:0] bv,
                             input logic [7:0] cv, input longint exp);
        int lat;
        start8(av, bv, cv);
        wait_done8(lat);
        check({name, "_lat"}, lat, 8);
        check({name, "_prod"}, longint'(prod8), exp);
        check({name, "_model"}, m8_prod, exp);
    endtask

    initial begin
        int lat;
        int dcount;
        arst = 1'b1;
        go8 = 1'b0; a8 = '0; b8 = '0; c8 = '0;
        go16 = 1'b0; a16 = '0; b16 = '0; c16 = '0;
        #1;
        check("rst_busy", longint'(busy8), 0);
        check("rst_done", longint'(done8), 0);
        check("rst_prod", longint'(prod8), 0);
        #11;
        arst = 1'b0;

        directed8("roundtrip", 8'd200, 8'd234, 8'd45, 46845);
        directed8("max",       8'd255, 8'd255, 8'd255, 65280);
        directed8("a_zero",    8'd0,   8'd77,  8'd9,   9);
        directed8("b_c_zero",  8'd123, 8'd0,   8'd0,   0);

        // Operand changes and a second go during RUN must not disturb the result.
        start8(8'd200, 8'd234, 8'd45);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #2;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
            go8 = (k == 3 || k == 5);
        end
        go8 = 1'b0;
        dcount = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done8) begin
                dcount++;
                check("stab_prod", longint'(prod8), 46845);
            end
        end
        check("stab_done_count", dcount, 1);

        // Back-to-back: go in the done cycle.
        start8(8'd10, 8'd10, 8'd5);
        wait_done8(lat);
        check("b2b_first", longint'(prod8), 105);
        a8 = 8'd3; b8 = 8'd4; c8 = 8'd1; go8 = 1'b1;
        @(posedge clk); #2;
        go8 = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_hold", longint'(prod8), 105);
        check("b2b_busy", longint'(busy8), 1);
        wait_done8(lat);
        check("b2b_lat", lat, 4);
        check("b2b_second", longint'(prod8), 13);

        // Asynchronous reset in the middle of an operation.
        start8(8'd100, 8'd3, 8'd7);
        repeat (4) @(posedge clk);
        #2 arst = 1'b1;
        #1;
        check("arst_busy", longint'(busy8), 0);
        check("arst_done", longint'(done8), 0);
        check("arst_prod", longint'(prod8), 0);
        #1 arst = 1'b0;
        directed8("after_rst", 8'd12, 8'd12, 8'd0, 144);

        // Random sweep on both widths in parallel.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    int l8;
                    logic [7:0] ra, rb, rc;
                    ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
                    start8(ra, rb, rc);
                    wait_done8(l8);
                    check("rnd8_lat", l8, 8);
                    check("rnd8_prod", longint'(prod8),
                          longint'(ra) * longint'(rb) + longint'(rc));
                end
            end
            begin
                for (int j = 0; j < 1000; j++) begin
                    int l16;
                    logic [15:0] sa, sb, sc;
                    sa = 16'($urandom); sb = 16'($urandom); sc = 16'($urandom);
                    if (j == 0) begin
                        sa = 16'hFFFF; sb = 16'hFFFF; sc = 16'hFFFF;
                    end
                    start16(sa, sb, sc);
                    wait_done16(l16);
                    check("rnd16_lat", l16, 16);
                    check("rnd16_prod", longint'(prod16),
                          longint'(sa) * longint'(sb) + longint'(sc));
                end
            end
        join

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/imadu.md
# imadu

Iterative unsigned multiply-add: computes `prod = a*b + c` by radix-2 shift-add, one multiplier bit per clock. It is the inverse companion of the unsigned divider: it feeds back `quot*divisor + rem` to rebuild and check the dividend. It also serves as the core's low-area multiplier. It uses the same single-cycle `go` / level `busy` handshake as the divider.

## Interface
- `WIDTH`, default 8: width of `a`, `b`, `c`. Product width is 2*`WIDTH`. Legal values are 2..32.
- `clk` input, 1 bit: the only clock. All state changes on its rising edge.
- `arst` input, 1 bit: reset. One clock; reset is asynchronous and active-high.
- `go` input, 1 bit: start request. Sampled on a rising edge while `busy`=0.
- `a` input, `WIDTH` bits: multiplicand (e.g. divisor).
- `b` input, `WIDTH` bits: multiplier (e.g. quotient).
- `c` input, `WIDTH` bits: addend (e.g. remainder).
- `busy` output, 1 bit: operation in progress.
- `done` output, 1 bit: one-cycle pulse when `prod` updates.
- `prod` output, 2*`WIDTH` bits: result register. Holds its value until the next completion.

## Operation
- Working register `P` is 2*`WIDTH` bits, plus a 1-bit carry. `A` is a `WIDTH`-bit capture of `a`. The iteration counter `n` has clog2(`WIDTH`+1) bits.
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- Transitions:
  - IDLE -> RUN on an edge with `go`=1. On that edge: `P` <= {`c`, `b`}, `A` <= `a`, `n` <= 0.
  - RUN, each edge: if `P[0]`, the upper half becomes upper+`A` (carry included). The result is then shifted right one bit with the carry entering the MSB, and `n` <= `n`+1.
  - RUN -> IDLE on the edge where `n` reaches `WIDTH`. On that edge: `prod` <= final `P`, and `done` <= 1.
- `done` is cleared on the following edge.
- No overflow is possible: the maximum result is (2^W−1)^2 + (2^W−1) = 2^2W − 2^W. The upper-half sum never exceeds 2^(W+1)−2, so one carry bit is sufficient.
- Preloading `c` in the upper half of `P` contributes exactly `c` after `WIDTH` right shifts.
- Inputs are captured only on the `go` edge. Changes to `a`, `b`, `c` during RUN have no effect.
- `go` while `busy`=1 is ignored: no restart and no queuing.
- `go` on the cycle `done`=1 is accepted, because `busy` is already 0.
- `prod` changes only on completion edges. It is stable during RUN and shows the previous result.

## Timing
- Reset values: `busy`=0, `done`=0, `prod`=0, `P`=0, `A`=0, `n`=0, state IDLE.
- Counting edges from the `go` capture edge E0:
  - `busy` rises after E0.
  - Iterations run on E1..E`WIDTH`.
  - `busy` falls and `prod` updates after E`WIDTH`.
  - `done` is high for exactly the cycle between E`WIDTH` and E`WIDTH`+1.
- Latency is `WIDTH` cycles from `busy` rising to `done` (8 for the default).
- Back-to-back throughput is one result per `WIDTH`+1 cycles.
- `arst` asserted mid-operation: all registers return to reset values immediately (asynchronous). No `done` is produced, and `prod` reads 0.
- After `arst` deasserts, the first `go` is honored on the first rising edge.

## Structure
- Single module `imadu`. No sub-module is needed; the adder is an inline `WIDTH`+1-bit sum.
- The shared arithmetic package holds:
  - the clog2 counter-width function, also used by `idivu`;
  - the default operand width constant (8), shared by `idivu` and `imadu` so their ports match when `imadu` checks divider results.

## Test plan
- Divider round trip: `a`=200, `b`=234, `c`=45, one-cycle `go` -> `busy` for 8 cycles, then `done` pulse with `prod`=46845.
- Extremes: `a`=255, `b`=255, `c`=255 -> `prod`=65280. Also `a`=0, `b`=77, `c`=9 -> `prod`=9. Also `b`=0, `c`=0 -> `prod`=0.
- Input stability: after `go`, change `a`/`b`/`c` every cycle and pulse `go` again during RUN -> the result matches the captured operands, and exactly one `done` is produced 8 cycles after the first `go`.
- Back-to-back: assert `go` in the `done` cycle with 3*4+1 after 10*10+5 -> `prod`=105, then `prod`=13 nine cycles later. `prod` holds 105 throughout the second RUN.
- Mid-operation reset: assert `arst` at iteration 4 -> `busy`, `done`, `prod` go to 0 asynchronously with no `done` pulse. A subsequent `go` with 12*12+0 gives `prod`=144.
- Random sweep with `WIDTH`=8 and `WIDTH`=16: 1000 operands, compared against a behavioral `a*b+c`, with latency checked at exactly `WIDTH` cycles.
